// File: rtl/mips_mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU control codes, mux selects and the FSM state enumeration.
package mips_mc_controller_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_NOP  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_PASSA = 4'b1010;
   localparam logic [3:0] ALU_SLTU  = 4'b1111;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
      S_RWB, S_JREX, S_BREX, S_IEXEC, S_IWB, S_JEX, S_JALEX
   } state_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle controller (master) and the datapath
// (slave): decoded instruction fields and flags in, mux/enable controls out.
interface mips_mc_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       pcen;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       signext;
   logic       shiftl16;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       jal;
   logic [3:0] alucontrol;
   logic       busy_err;
   logic       illegal;

   modport master (
      input  op, funct, zero, mem_ready,
      output iord, memread, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
             signext, shiftl16, regdst, memtoreg, regwrite, jal, alucontrol,
             busy_err, illegal
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  iord, memread, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
             signext, shiftl16, regdst, memtoreg, regwrite, jal, alucontrol,
             busy_err, illegal
   );
endinterface

// File: rtl/mips_mc_controller_aludec.sv
// R-type funct decoder: maps funct to the ALU control code and flags any
// funct outside the supported set.
module mips_mc_controller_aludec
   import mips_mc_controller_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alucontrol,
   output logic       illegal
);
   always_comb begin
      alucontrol = ALU_AND;
      illegal    = 1'b0;
      case (funct)
         FN_NOP:          alucontrol = ALU_AND;
         FN_JR:           alucontrol = ALU_PASSA;
         FN_ADD, FN_ADDU: alucontrol = ALU_ADD;
         FN_SUB, FN_SUBU: alucontrol = ALU_SUB;
         FN_AND:          alucontrol = ALU_AND;
         FN_OR:           alucontrol = ALU_OR;
         FN_SLT:          alucontrol = ALU_SLT;
         FN_SLTU:         alucontrol = ALU_SLTU;
         default:         illegal    = 1'b1;
      endcase
   end
endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with a variable-latency memory handshake,
// memory-wait timeout and illegal-instruction detection.
module mips_mc_controller
   import mips_mc_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)
(
   input logic                 clk,
   input logic                 reset,
   mips_mc_controller_if.master bus
);
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic [3:0]       funct_alu;
   logic             funct_bad;
   logic             mem_state;
   logic             timeout;

   mips_mc_controller_aludec u_mc_aludec (
      .funct      (bus.funct),
      .alucontrol (funct_alu),
      .illegal    (funct_bad)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_FETCH;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   assign mem_state = state_reg inside {S_FETCH, S_MEMRD, S_MEMWR};
   assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready &&
                      (wait_cnt_reg == CNT_W'(MEM_TIMEOUT));

   always_comb begin
      state_next     = state_reg;
      bus.iord       = 1'b0;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.pcen       = 1'b0;
      bus.pcsrc      = PCSRC_ALU;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = SRCB_B;
      bus.signext    = 1'b0;
      bus.shiftl16   = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.jal        = 1'b0;
      bus.alucontrol = ALU_ADD;
      bus.busy_err   = 1'b0;
      bus.illegal    = 1'b0;

      case (state_reg)
         S_FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = SRCB_FOUR;
            if (timeout) begin
               bus.busy_err = 1'b1;
            end else if (bus.mem_ready) begin
               bus.irwrite = 1'b1;
               bus.pcen    = 1'b1;
               state_next  = S_DECODE;
            end
         end
         S_DECODE: begin
            bus.alusrcb = SRCB_IMM_SL2;
            bus.signext = 1'b1;
            case (bus.op)
               OP_LW, OP_SW:                     state_next = S_MEMADR;
               OP_RTYPE:                         state_next = S_REXEC;
               OP_BEQ, OP_BNE:                   state_next = S_BREX;
               OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_next = S_IEXEC;
               OP_J:                             state_next = S_JEX;
               OP_JAL:                           state_next = S_JALEX;
               default: begin
                  bus.illegal = 1'b1;
                  state_next  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            bus.signext = 1'b1;
            state_next  = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
            if (timeout) begin
               bus.busy_err = 1'b1;
               state_next   = S_FETCH;
            end else if (bus.mem_ready) begin
               state_next = S_MEMWB;
            end
         end
         S_MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEMWR: begin
            bus.iord = 1'b1;
            if (timeout) begin
               bus.busy_err = 1'b1;
               state_next   = S_FETCH;
            end else if (bus.mem_ready) begin
               bus.memwrite = 1'b1;
               state_next   = S_FETCH;
            end
         end
         S_REXEC: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = funct_alu;
            if (bus.funct == FN_JR) begin
               state_next = S_JREX;
            end else if (funct_bad) begin
               bus.illegal = 1'b1;
               state_next  = S_FETCH;
            end else begin
               state_next = S_RWB;
            end
         end
         S_RWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 1'b1;
            state_next   = S_FETCH;
         end
         S_JREX: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = ALU_PASSA;
            bus.pcen       = 1'b1;
            state_next     = S_FETCH;
         end
         S_BREX: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = ALU_SUB;
            bus.pcsrc      = PCSRC_ALUOUT;
            bus.pcen       = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
            state_next     = S_FETCH;
         end
         S_IEXEC: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            case (bus.op)
               OP_ORI:  bus.alucontrol = ALU_OR;
               OP_LUI:  bus.shiftl16   = 1'b1;
               default: bus.signext    = 1'b1;
            endcase
            state_next = S_IWB;
         end
         S_IWB: begin
            bus.regwrite = 1'b1;
            state_next   = S_FETCH;
         end
         S_JEX: begin
            bus.pcsrc  = PCSRC_JUMP;
            bus.pcen   = 1'b1;
            state_next = S_FETCH;
         end
         S_JALEX: begin
            // PC already holds PC+4 here, so the link value is taken directly from PC
            bus.jal      = 1'b1;
            bus.regwrite = 1'b1;
            bus.pcsrc    = PCSRC_JUMP;
            bus.pcen     = 1'b1;
            state_next   = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase

      if (timeout || (state_next != state_reg)) begin
         wait_cnt_next = '0;
      end else if (mem_state && !bus.mem_ready && (MEM_TIMEOUT != 0)) begin
         wait_cnt_next = wait_cnt_reg + CNT_W'(1);
      end else begin
         wait_cnt_next = wait_cnt_reg;
      end

      // Asynchronous reset must silence every write enable and pulse immediately
      if (!reset) begin
         bus.memwrite = 1'b0;
         bus.irwrite  = 1'b0;
         bus.pcen     = 1'b0;
         bus.regwrite = 1'b0;
         bus.busy_err = 1'b0;
         bus.illegal  = 1'b0;
      end
   end
endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for the multicycle controller: walks instruction sequences
// cycle by cycle and compares control outputs to hand-derived values.
module tb_mips_mc_controller;
   import mips_mc_controller_pkg::*;

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   mips_mc_controller_if bus ();

   mips_mc_controller #(.MEM_TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock, drive mem_ready for the new cycle and let outputs settle
   task automatic step(input logic rdy);
      @(posedge clk);
      #1;
      bus.mem_ready = rdy;
      #1;
   endtask

   logic [5:0] fn_tab  [7] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU, FN_NOP};
   logic [3:0] alu_tab [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111, 4'b0000};

   initial begin
      reset         = 1'b0;
      bus.op        = OP_LW;
      bus.funct     = FN_ADD;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;

      // Reset held: enables stay low even though mem_ready=1 in FETCH
      #12;
      check_eq("rst_irwrite",  4'(bus.irwrite),  4'h0);
      check_eq("rst_pcen",     4'(bus.pcen),     4'h0);
      check_eq("rst_memwrite", 4'(bus.memwrite), 4'h0);
      check_eq("rst_regwrite", 4'(bus.regwrite), 4'h0);
      check_eq("rst_busy_err", 4'(bus.busy_err), 4'h0);
      check_eq("rst_illegal",  4'(bus.illegal),  4'h0);
      reset = 1'b1;
      #1;
      $display("[TB] reset released");

      // LW: FETCH, DECODE, MEMADR, MEMRD, MEMWB, back to FETCH on cycle 6
      check_eq("lw_c1_memread", 4'(bus.memread), 4'h1);
      check_eq("lw_c1_iord",    4'(bus.iord),    4'h0);
      check_eq("lw_c1_irwrite", 4'(bus.irwrite), 4'h1);
      check_eq("lw_c1_pcen",    4'(bus.pcen),    4'h1);
      step(1'b1);
      check_eq("lw_c2_alusrcb", 4'(bus.alusrcb), 4'h3);
      check_eq("lw_c2_signext", 4'(bus.signext), 4'h1);
      step(1'b1);
      check_eq("lw_c3_alusrca", 4'(bus.alusrca), 4'h1);
      check_eq("lw_c3_alusrcb", 4'(bus.alusrcb), 4'h2);
      step(1'b1);
      check_eq("lw_c4_iord",    4'(bus.iord),    4'h1);
      check_eq("lw_c4_memread", 4'(bus.memread), 4'h1);
      step(1'b1);
      check_eq("lw_c5_regwrite", 4'(bus.regwrite), 4'h1);
      check_eq("lw_c5_memtoreg", 4'(bus.memtoreg), 4'h1);
      check_eq("lw_c5_regdst",   4'(bus.regdst),   4'h0);
      step(1'b1);
      check_eq("lw_c6_memread", 4'(bus.memread), 4'h1);
      check_eq("lw_c6_iord",    4'(bus.iord),    4'h0);
      check_eq("lw_c6_irwrite", 4'(bus.irwrite), 4'h1);
      $display("[TB] LW r2,4(r1) sequence");

      // BEQ taken (zero=1)
      bus.op = OP_BEQ; bus.zero = 1'b1;
      step(1'b1);
      step(1'b1);
      check_eq("beq_pcen",  4'(bus.pcen),       4'h1);
      check_eq("beq_pcsrc", 4'(bus.pcsrc),      4'h1);
      check_eq("beq_alu",   bus.alucontrol,     4'h6);
      step(1'b1);
      check_eq("beq_c4_fetch_irwrite", 4'(bus.irwrite), 4'h1);
      $display("[TB] BEQ zero=1 sequence");

      // BNE not taken (zero=1)
      bus.op = OP_BNE;
      step(1'b1);
      step(1'b1);
      check_eq("bne_pcen",  4'(bus.pcen),  4'h0);
      check_eq("bne_pcsrc", 4'(bus.pcsrc), 4'h1);
      step(1'b1);
      check_eq("bne_c4_fetch_irwrite", 4'(bus.irwrite), 4'h1);
      bus.zero = 1'b0;
      $display("[TB] BNE zero=1 sequence");

      // JAL
      bus.op = OP_JAL;
      step(1'b1);
      step(1'b1);
      check_eq("jal_jal",      4'(bus.jal),      4'h1);
      check_eq("jal_regwrite", 4'(bus.regwrite), 4'h1);
      check_eq("jal_pcsrc",    4'(bus.pcsrc),    4'h2);
      check_eq("jal_pcen",     4'(bus.pcen),     4'h1);
      step(1'b1);
      check_eq("jal_c4_fetch_irwrite", 4'(bus.irwrite), 4'h1);
      $display("[TB] JAL sequence");

      // JR: FETCH, DECODE, REXEC, JREX
      bus.op = OP_RTYPE; bus.funct = FN_JR;
      step(1'b1);
      step(1'b1);
      check_eq("jr_rexec_regwrite", 4'(bus.regwrite), 4'h0);
      step(1'b1);
      check_eq("jr_alu",     bus.alucontrol,    4'hA);
      check_eq("jr_pcsrc",   4'(bus.pcsrc),     4'h0);
      check_eq("jr_pcen",    4'(bus.pcen),      4'h1);
      check_eq("jr_alusrca", 4'(bus.alusrca),   4'h1);
      step(1'b1);
      check_eq("jr_fetch_irwrite", 4'(bus.irwrite), 4'h1);
      $display("[TB] JR sequence");

      // R-type functs through REXEC and RWB
      for (int i = 0; i < 7; i++) begin
         bus.op = OP_RTYPE; bus.funct = fn_tab[i];
         step(1'b1);
         step(1'b1);
         check_eq($sformatf("rexec_alu_%0d", i),     bus.alucontrol,   alu_tab[i]);
         check_eq($sformatf("rexec_srcb_%0d", i),    4'(bus.alusrcb),  4'h0);
         check_eq($sformatf("rexec_illegal_%0d", i), 4'(bus.illegal),  4'h0);
         step(1'b1);
         check_eq($sformatf("rwb_regwrite_%0d", i),  4'(bus.regwrite), 4'h1);
         check_eq($sformatf("rwb_regdst_%0d", i),    4'(bus.regdst),   4'h1);
         check_eq($sformatf("rwb_memtoreg_%0d", i),  4'(bus.memtoreg), 4'h0);
         step(1'b1);
         check_eq($sformatf("rtype_fetch_%0d", i),   4'(bus.irwrite),  4'h1);
         $display("[TB] R-type funct=%b alucontrol=%b", fn_tab[i], bus.alucontrol);
      end

      // FETCH stalled 3 cycles, completes on the 4th; then J
      bus.op = OP_J;
      bus.mem_ready = 1'b0;
      #1;
      check_eq("stall1_irwrite", 4'(bus.irwrite), 4'h0);
      check_eq("stall1_pcen",    4'(bus.pcen),    4'h0);
      step(1'b0);
      check_eq("stall2_irwrite", 4'(bus.irwrite), 4'h0);
      step(1'b0);
      check_eq("stall3_pcen",    4'(bus.pcen),    4'h0);
      check_eq("stall3_memread", 4'(bus.memread), 4'h1);
      step(1'b1);
      check_eq("stall4_irwrite", 4'(bus.irwrite), 4'h1);
      check_eq("stall4_pcen",    4'(bus.pcen),    4'h1);
      step(1'b1);
      step(1'b1);
      check_eq("j_pcsrc", 4'(bus.pcsrc), 4'h2);
      check_eq("j_pcen",  4'(bus.pcen),  4'h1);
      step(1'b1);
      $display("[TB] stalled fetch then J sequence");

      // Timeout: 16 wait cycles, busy_err on the 17th, counter restarts after
      bus.mem_ready = 1'b0;
      #1;
      check_eq("to_cycle1_busy", 4'(bus.busy_err), 4'h0);
      for (int c = 2; c <= 18; c++) begin
         step(1'b0);
         if (c >= 15) begin
            check_eq($sformatf("to_cycle%0d_busy", c), 4'(bus.busy_err), (c == 17) ? 4'h1 : 4'h0);
            check_eq($sformatf("to_cycle%0d_memread", c), 4'(bus.memread), 4'h1);
            check_eq($sformatf("to_cycle%0d_irwrite", c), 4'(bus.irwrite), 4'h0);
            check_eq($sformatf("to_cycle%0d_pcen", c),    4'(bus.pcen),    4'h0);
         end
      end
      $display("[TB] fetch timeout sequence");

      // Illegal opcode: pulse in DECODE, straight back to FETCH
      bus.op = 6'b111111;
      step(1'b1);
      check_eq("illop_fetch_busy", 4'(bus.busy_err), 4'h0);
      step(1'b1);
      check_eq("illop_illegal",  4'(bus.illegal),  4'h1);
      check_eq("illop_regwrite", 4'(bus.regwrite), 4'h0);
      check_eq("illop_memwrite", 4'(bus.memwrite), 4'h0);
      step(1'b1);
      check_eq("illop_next_illegal", 4'(bus.illegal), 4'h0);
      check_eq("illop_next_irwrite", 4'(bus.irwrite), 4'h1);
      $display("[TB] illegal opcode sequence");

      // Illegal funct: pulse in REXEC, back to FETCH without RWB
      bus.op = OP_RTYPE; bus.funct = 6'b111111;
      step(1'b1);
      check_eq("illfn_decode_illegal", 4'(bus.illegal), 4'h0);
      step(1'b1);
      check_eq("illfn_illegal",  4'(bus.illegal),  4'h1);
      check_eq("illfn_regwrite", 4'(bus.regwrite), 4'h0);
      step(1'b1);
      check_eq("illfn_next_regwrite", 4'(bus.regwrite), 4'h0);
      check_eq("illfn_next_irwrite",  4'(bus.irwrite),  4'h1);
      $display("[TB] illegal funct sequence");

      // SW, reset asserted mid-MEMWR
      bus.op = OP_SW;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      check_eq("sw_memwrite", 4'(bus.memwrite), 4'h1);
      check_eq("sw_iord",     4'(bus.iord),     4'h1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("rst_mid_memwrite", 4'(bus.memwrite), 4'h0);
      check_eq("rst_mid_irwrite",  4'(bus.irwrite),  4'h0);
      @(posedge clk);
      #5;
      reset = 1'b1;
      #1;
      check_eq("post_rst_memread", 4'(bus.memread),  4'h1);
      check_eq("post_rst_iord",    4'(bus.iord),     4'h0);
      check_eq("post_rst_irwrite", 4'(bus.irwrite),  4'h1);
      check_eq("post_rst_busy",    4'(bus.busy_err), 4'h0);
      check_eq("post_rst_illegal", 4'(bus.illegal),  4'h0);
      $display("[TB] reset during MEMWR sequence");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
